// File: rtl/dct_uart_ctrl.sv
// Frame sequencer between UART byte streams and dct_core: packs 32 rx bytes into a
// 256-bit vector, starts the core, captures its result and streams it back out as 32 bytes.
//
// state | meaning
// IDLE  | waiting for the first byte of a frame
// LOAD  | shifting in bytes until the frame is complete
// START | single-cycle start pulse to dct_core, dct_in held
// WAIT  | waiting for dct_done under watchdog
// SEND  | serialising the captured result over valid/ready
module dct_uart_ctrl #(
    parameter int N_BYTES = 32,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic [8*N_BYTES-1:0]   dct_in,
    output logic                   dct_start,
    input  logic [8*N_BYTES-1:0]   dct_out,
    input  logic                   dct_done,
    output logic                   busy,
    output logic                   rx_overrun,
    output logic                   err_timeout
);

    localparam int FRAME_W = 8 * N_BYTES;
    localparam int BC_W    = $clog2(N_BYTES + 1);
    localparam int IDX_W   = $clog2(N_BYTES);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        SEND  = 3'd4
    } state_t;

    state_t             state, state_n;
    logic [BC_W-1:0]    cnt, cnt_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [CNT_W-1:0]   wd, wd_n;
    logic [FRAME_W-1:0] din_n;
    logic [FRAME_W-1:0] result, res_n;
    logic [FRAME_W-1:0] res_sh;
    logic [7:0]         tx_data_n;
    logic               tx_valid_n, start_n, busy_n, ovr_n, tmo_n;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        wd_n    = wd;
        din_n   = dct_in;
        res_n   = result;
        ovr_n   = 1'b0;
        tmo_n   = 1'b0;
        case (state)
            IDLE: begin
                if (rx_valid) begin
                    din_n   = {dct_in[FRAME_W-9:0], rx_data};
                    cnt_n   = BC_W'(1);
                    state_n = LOAD;
                end
            end
            LOAD: begin
                if (rx_valid) begin
                    din_n = {dct_in[FRAME_W-9:0], rx_data};
                    cnt_n = cnt + BC_W'(1);
                    if (cnt == BC_W'(N_BYTES - 1)) state_n = START;
                end
            end
            START: begin
                ovr_n   = rx_valid;
                wd_n    = '0;
                state_n = WAIT;
            end
            WAIT: begin
                ovr_n = rx_valid;
                wd_n  = wd + CNT_W'(1);
                // done is checked first so a completion on the last watchdog cycle still counts
                if (dct_done) begin
                    res_n   = dct_out;
                    idx_n   = '0;
                    state_n = SEND;
                end else if (wd == CNT_W'(TIMEOUT - 1)) begin
                    tmo_n   = 1'b1;
                    wd_n    = '0;
                    cnt_n   = '0;
                    state_n = IDLE;
                end
            end
            SEND: begin
                ovr_n = rx_valid;
                if (tx_ready) begin
                    if (idx == IDX_W'(N_BYTES - 1)) begin
                        idx_n   = '0;
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Outputs are registered from next-state values; overrun/timeout pulses land one cycle after their cause
        res_sh     = res_n << {idx_n, 3'b000};
        tx_valid_n = (state_n == SEND);
        tx_data_n  = tx_valid_n ? res_sh[FRAME_W-1 -: 8] : 8'h00;
        start_n    = (state_n == START);
        busy_n     = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            wd          <= '0;
            dct_in      <= '0;
            result      <= '0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            dct_start   <= 1'b0;
            busy        <= 1'b0;
            rx_overrun  <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            wd          <= wd_n;
            dct_in      <= din_n;
            result      <= res_n;
            tx_data     <= tx_data_n;
            tx_valid    <= tx_valid_n;
            dct_start   <= start_n;
            busy        <= busy_n;
            rx_overrun  <= ovr_n;
            err_timeout <= tmo_n;
        end
    end

endmodule

// File: tb/tb_dct_uart_ctrl.sv
// Directed self-checking bench for dct_uart_ctrl: frames, backpressure, watchdog, overrun, reset, spurious done.
module tb_dct_uart_ctrl;

    localparam logic [255:0] F00 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] R01 = 256'h0102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f20;
    localparam logic [255:0] R80 = 256'h808182838485868788898a8b8c8d8e8f909192939495969798999a9b9c9d9e9f;
    localparam logic [255:0] F60 = 256'h606162636465666768696a6b6c6d6e6f707172737475767778797a7b7c7d7e7f;
    localparam logic [255:0] FA0 = 256'ha0a1a2a3a4a5a6a7a8a9aaabacadaeafb0b1b2b3b4b5b6b7b8b9babbbcbdbebf;
    localparam logic [255:0] FC0 = 256'hc0c1c2c3c4c5c6c7c8c9cacbcccdcecfd0d1d2d3d4d5d6d7d8d9dadbdcdddedf;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [7:0]   rx_data = '0;
    logic         rx_valid = 1'b0;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready = 1'b0;
    logic [255:0] dct_in;
    logic         dct_start;
    logic [255:0] dct_out = '0;
    logic         dct_done = 1'b0;
    logic         busy;
    logic         rx_overrun;
    logic         err_timeout;

    int errors = 0;
    int checks = 0;
    int n_start = 0, n_ovr = 0, n_tmo = 0;
    logic [7:0] got[32];
    int n_got;
    int stall_bad;

    dct_uart_ctrl dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .dct_in(dct_in), .dct_start(dct_start), .dct_out(dct_out), .dct_done(dct_done),
        .busy(busy), .rx_overrun(rx_overrun), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dct_start === 1'b1) n_start++;
        if (rx_overrun === 1'b1) n_ovr++;
        if (err_timeout === 1'b1) n_tmo++;
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic load_frame(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) send_byte(base + 8'(i));
    endtask

    task automatic pulse_done(input logic [255:0] v);
        dct_done = 1'b1;
        dct_out  = v;
        @(negedge clk);
        dct_done = 1'b0;
    endtask

    task automatic do_reset;
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
    endtask

    // Accepts bytes with tx_ready following pat cyclically; records accepted bytes and stall-instability events
    task automatic collect(input logic [3:0] pat);
        logic [7:0] prev;
        logic       prev_stall;
        int         k;
        n_got = 0; stall_bad = 0; prev_stall = 1'b0; prev = '0; k = 0;
        for (int c = 0; c < 400 && n_got < 32; c++) begin
            if (prev_stall && tx_data !== prev) stall_bad++;
            if (tx_valid !== 1'b1) begin
                tx_ready   = 1'b0;
                prev_stall = 1'b0;
            end else begin
                tx_ready = pat[k % 4];
                k++;
                if (tx_ready) begin
                    got[n_got] = tx_data;
                    n_got++;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    prev       = tx_data;
                end
            end
            @(negedge clk);
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
        checks++; if (dct_start !== 1'b0) begin errors++; $display("FAIL reset_dct_start: got %b expected 0", dct_start); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (rx_overrun !== 1'b0 || err_timeout !== 1'b0) begin errors++; $display("FAIL reset_pulses: got ovr=%b tmo=%b expected 0 0", rx_overrun, err_timeout); end
        checks++; if (dct_in !== '0) begin errors++; $display("FAIL reset_dct_in: got %h expected 0", dct_in); end
    endtask

    task automatic test_single_frame;
        int s0;
        s0 = n_start;
        load_frame(8'h00, 32);
        checks++; if (dct_start !== 1'b1) begin errors++; $display("FAIL single_start_latency: got %b expected 1", dct_start); end
        checks++; if (dct_in !== F00) begin errors++; $display("FAIL single_dct_in: got %h expected %h", dct_in, F00); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
        repeat (10) tick();
        pulse_done(R01);
        collect(4'b1111);
        checks++; if (n_got !== 32) begin errors++; $display("FAIL single_tx_count: got %0d expected 32", n_got); end
        for (int i = 0; i < 32; i++) begin
            checks++; if (got[i] !== 8'h01 + 8'(i)) begin errors++; $display("FAIL single_tx_byte[%0d]: got %h expected %h", i, got[i], 8'h01 + 8'(i)); end
        end
        checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_end: got tx_valid=%b busy=%b expected 0 0", tx_valid, busy); end
        checks++; if (n_start - s0 !== 1) begin errors++; $display("FAIL single_start_count: got %0d expected 1", n_start - s0); end
    endtask

    task automatic test_backpressure_back_to_back;
        load_frame(8'h40, 32);
        repeat (4) tick();
        pulse_done(R80);
        collect(4'b1001);
        checks++; if (n_got !== 32) begin errors++; $display("FAIL bp_tx_count: got %0d expected 32", n_got); end
        for (int i = 0; i < 32; i++) begin
            checks++; if (got[i] !== 8'h80 + 8'(i)) begin errors++; $display("FAIL bp_tx_byte[%0d]: got %h expected %h", i, got[i], 8'h80 + 8'(i)); end
        end
        checks++; if (stall_bad !== 0) begin errors++; $display("FAIL bp_stall_stable: got %0d changes expected 0", stall_bad); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL bp_no_extra: got tx_valid=%b expected 0", tx_valid); end
        // first byte of the next frame lands in the very first IDLE cycle
        load_frame(8'h00, 32);
        checks++; if (dct_start !== 1'b1 || dct_in !== F00) begin errors++; $display("FAIL b2b_frame: got start=%b dct_in=%h expected 1 %h", dct_start, dct_in, F00); end
        do_reset();
    endtask

    task automatic test_timeout;
        int first, t0;
        logic busy_at, saw_tx;
        first = 0; busy_at = 1'b1; saw_tx = 1'b0; t0 = n_tmo;
        load_frame(8'h00, 32);
        for (int k = 1; k <= 80; k++) begin
            tick();
            if (err_timeout === 1'b1 && first == 0) begin first = k; busy_at = busy; end
            if (tx_valid !== 1'b0) saw_tx = 1'b1;
        end
        checks++; if (first !== 65) begin errors++; $display("FAIL timeout_cycle: got %0d expected 65", first); end
        checks++; if (busy_at !== 1'b0) begin errors++; $display("FAIL timeout_idle: got busy=%b expected 0", busy_at); end
        checks++; if (saw_tx !== 1'b0) begin errors++; $display("FAIL timeout_no_tx: got %b expected 0", saw_tx); end
        checks++; if (n_tmo - t0 !== 1) begin errors++; $display("FAIL timeout_pulses: got %0d expected 1", n_tmo - t0); end
        load_frame(8'h60, 32);
        checks++; if (dct_in !== F60) begin errors++; $display("FAIL timeout_next_dct_in: got %h expected %h", dct_in, F60); end
        repeat (3) tick();
        pulse_done(R80);
        collect(4'b1111);
        checks++; if (n_got !== 32 || got[0] !== 8'h80 || got[31] !== 8'h9f) begin errors++; $display("FAIL timeout_next_tx: got n=%0d first=%h last=%h expected 32 80 9f", n_got, got[0], got[31]); end
    endtask

    task automatic test_overrun;
        int o0, bad;
        o0 = n_ovr; bad = 0;
        load_frame(8'h00, 32);
        send_byte(8'hEE);
        send_byte(8'hEF);
        send_byte(8'hF0);
        tick();
        checks++; if (n_ovr - o0 !== 3) begin errors++; $display("FAIL overrun_pulses: got %0d expected 3", n_ovr - o0); end
        checks++; if (dct_in !== F00) begin errors++; $display("FAIL overrun_dct_in: got %h expected %h", dct_in, F00); end
        pulse_done(R01);
        collect(4'b1111);
        for (int i = 0; i < 32; i++) if (got[i] !== 8'h01 + 8'(i)) bad++;
        checks++; if (n_got !== 32 || bad !== 0) begin errors++; $display("FAIL overrun_result: got n=%0d bad=%0d expected 32 0", n_got, bad); end
        load_frame(8'h60, 32);
        checks++; if (dct_start !== 1'b1 || dct_in !== F60) begin errors++; $display("FAIL overrun_next_frame: got start=%b dct_in=%h expected 1 %h", dct_start, dct_in, F60); end
        do_reset();
    endtask

    task automatic test_reset_mid_frame;
        int s0;
        s0 = n_start;
        load_frame(8'h40, 17);
        do_reset();
        checks++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin errors++; $display("FAIL midrst_idle: got busy=%b tx_valid=%b expected 0 0", busy, tx_valid); end
        repeat (3) tick();
        load_frame(8'hA0, 31);
        checks++; if (n_start !== s0) begin errors++; $display("FAIL midrst_no_start: got %0d starts expected 0", n_start - s0); end
        send_byte(8'hBF);
        checks++; if (dct_start !== 1'b1 || dct_in !== FA0) begin errors++; $display("FAIL midrst_frame: got start=%b dct_in=%h expected 1 %h", dct_start, dct_in, FA0); end
        do_reset();
    endtask

    task automatic test_spurious_done;
        int t0;
        t0 = n_tmo;
        pulse_done(R80);
        checks++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin errors++; $display("FAIL spur_idle: got busy=%b tx_valid=%b expected 0 0", busy, tx_valid); end
        load_frame(8'hC0, 5);
        pulse_done(R80);
        checks++; if (busy !== 1'b1 || tx_valid !== 1'b0 || dct_start !== 1'b0) begin errors++; $display("FAIL spur_load: got busy=%b tx_valid=%b start=%b expected 1 0 0", busy, tx_valid, dct_start); end
        load_frame(8'hC5, 27);
        checks++; if (dct_start !== 1'b1 || dct_in !== FC0) begin errors++; $display("FAIL spur_frame: got start=%b dct_in=%h expected 1 %h", dct_start, dct_in, FC0); end
        repeat (64) tick();
        pulse_done(R01);
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h01 || err_timeout !== 1'b0) begin errors++; $display("FAIL edge_done_wins: got tx_valid=%b tx_data=%h tmo=%b expected 1 01 0", tx_valid, tx_data, err_timeout); end
        collect(4'b1111);
        checks++; if (n_got !== 32 || got[31] !== 8'h20) begin errors++; $display("FAIL edge_done_tx: got n=%0d last=%h expected 32 20", n_got, got[31]); end
        checks++; if (n_tmo !== t0) begin errors++; $display("FAIL edge_no_timeout: got %0d pulses expected 0", n_tmo - t0); end
    endtask

    initial begin
        tick();
        test_reset();
        test_single_frame();
        test_backpressure_back_to_back();
        test_timeout();
        test_overrun();
        test_reset_mid_frame();
        test_spurious_done();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dct_uart_ctrl.md
Name: dct_uart_ctrl

Overview:
Frame sequencer between the UART byte streams and dct_core. It assembles 32 received bytes into one 256-bit sample vector and issues a single-cycle start to dct_core. It then waits for done, captures the 256-bit result and serialises it back out as 32 bytes over a valid/ready transmit interface. A watchdog recovers the block if the core never completes.

Parameters:
N_BYTES, 32, bytes per frame (8 words x 4 bytes); frame width is 8*N_BYTES.
TIMEOUT, 64, maximum cycles in WAIT before abort; must be >= core latency.
CNT_W, 7, width of the watchdog counter; must hold TIMEOUT.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-high (asserted = 1 resets block)
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe, rx_data valid
tx_data  out  8  byte to transmit
tx_valid  out  1  tx_data valid
tx_ready  in  1  transmitter accepts byte when tx_valid & tx_ready
dct_in  out  256  sample vector to dct_core a1 input
dct_start  out  1  one-cycle start pulse to dct_core
dct_out  in  256  dct_core final_output
dct_done  in  1  dct_core done pulse; dct_out valid in same cycle
busy  out  1  high in every state except IDLE
rx_overrun  out  1  one-cycle pulse when a byte is discarded
err_timeout  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (rst_n=1 at clk edge): state=IDLE; byte counter=0; watchdog=0; dct_in=0; result register=0. Outputs: tx_data=0, tx_valid=0, dct_start=0, busy=0, rx_overrun=0, err_timeout=0.
- States: IDLE, LOAD, START, WAIT, SEND.
- IDLE:
  - rx_valid shifts the byte into dct_in from the right (dct_in <= {dct_in[247:0], rx_data}).
  - Counter becomes 1; go to LOAD.
  - Net effect: the first received byte lands in dct_in[255:248], so word 0 is big-endian.
- LOAD:
  - Each rx_valid shifts in one byte and increments the counter.
  - On the byte that makes count == N_BYTES, go to START.
  - No timeout in LOAD; partial frames wait indefinitely.
- START:
  - dct_start=1 for exactly this one cycle; dct_in is held stable.
  - Go to WAIT with watchdog=0.
  - Latency: last rx byte at edge T gives dct_start high in cycle T+1.
- WAIT:
  - Watchdog increments every cycle.
  - dct_done=1: capture dct_out into the result register, byte index=0, go to SEND.
  - Watchdog reaching TIMEOUT-1 without done: pulse err_timeout, clear counters, go to IDLE; dct_in keeps its last value.
  - If done and the timeout fire in the same cycle, done wins.
- SEND:
  - tx_valid=1; tx_data = result byte [255-8*i -: 8] for byte index i.
  - On tx_valid & tx_ready, i increments and the next byte is presented in the following cycle (back-to-back allowed).
  - tx_data must stay stable while tx_valid & !tx_ready.
  - After byte N_BYTES-1 is accepted: tx_valid=0 next cycle, go to IDLE.
- rx_valid in START, WAIT or SEND: byte discarded, rx_overrun=1 that cycle; dct_in and counters untouched.
- dct_done outside WAIT: ignored, with no capture and no state change.
- Simultaneous rx_valid and the IDLE entry from SEND: a byte arriving in the first IDLE cycle is accepted normally.
- dct_start is never asserted outside START; at most one start per frame.
- Reset mid-operation: any state returns to IDLE next cycle, partial frame discarded, tx_valid drops immediately, no trailing start.
- busy = (state != IDLE); all outputs registered.

Test Plan:
- Single frame: send bytes 0x00..0x1F, model dct_done 10 cycles after start with dct_out = 256'h0102...20 → dct_in = 256'h00010203...1F at start, exactly one dct_start, 32 tx bytes 0x01..0x20 in order with tx_ready held 1, busy low after last.
- Backpressure: tx_ready toggles 1,0,0,1 per cycle during SEND → every byte sent exactly once, in order; tx_data stable while stalled; no duplicates.
- Timeout: TIMEOUT=64, never assert dct_done → err_timeout pulses on the 64th WAIT cycle, state IDLE, tx_valid never asserted; next frame works normally.
- Overrun: 3 extra bytes pushed during WAIT → rx_overrun pulses 3 times, result unchanged, next frame loads from byte 0 correctly.
- Reset mid-frame: rst_n=1 after 17 bytes, then 32 fresh bytes 0xA0..0xBF → dct_in = 256'hA0A1...BF, no start during or after the reset.
- Spurious done: dct_done pulsed in IDLE and LOAD → ignored; done and the watchdog expiry in the same cycle → capture taken, no err_timeout.
